seq_100bit_subtractor: RTL and testbench
========================================

Name: seq_100bit_subtractor

Overview:
- Multi-cycle 100-bit subtractor; the inverse operation of the 100-bit combinational adder.
- Computes Diff = A - B - Bin and a borrow-out, one CHUNK-bit slice per clock.
- Ripples an internal carry between slices.
- Uses valid/ready handshakes on both sides so it can sit between a stimulus source and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 100, operand and result width in bits.
- CHUNK, 25, bits processed per clock; WIDTH must be an exact multiple of CHUNK (elaboration error otherwise).
- NCHUNK, WIDTH/CHUNK (derived, localparam), number of compute cycles (4 by default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands A, B, Bin are valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  Diff/Bout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
- Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).

Behaviour:
- Reset (async, active-high): state=IDLE; out_valid=0; Diff=0; Bout=0; slice index=0; internal carry=0; operand registers=0. in_ready=1 while in IDLE, including during reset.
- in_ready is combinational: 1 only in IDLE. out_valid is registered: 1 only in DONE.
- IDLE:
  - On a clock edge with in_valid=1, latch A, ~B and carry=~Bin; clear slice index; go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Each edge, for slice i: {c, Diff[i*CHUNK +: CHUNK]} = Aslice + ~Bslice + carry; carry <= c; i <= i+1.
  - in_valid is ignored.
  - On the edge processing slice NCHUNK-1: Bout <= ~c and go to DONE.
- DONE:
  - out_valid=1; Diff and Bout stable.
  - On an edge with out_ready=1, go to IDLE.
  - No operand is accepted in the same cycle as result hand-off; in_ready first rises in the cycle after.
- Latency: acceptance edge k → out_valid=1 after edge k+NCHUNK.
- Minimum initiation interval: NCHUNK+2 cycles (4-cycle compute default, 6-cycle II).
- Diff bits of not-yet-computed slices retain prior values during CALC. Consumers sample only when out_valid=1.
- After hand-off, Diff/Bout hold their last values until overwritten by the next computation.
- Arithmetic: two's-complement via add of inverted B with carry-in ~Bin. Carry out of the top slice is inverted to form Bout. Wrap-around is modulo 2^WIDTH; no saturation.
- Backpressure: out_ready=0 holds DONE indefinitely; outputs unchanged; in_valid ignored.
- Reset mid-CALC or mid-DONE: immediately abort to IDLE with all outputs cleared; the partial result is discarded.
- in_valid/operand changes after acceptance have no effect on the current result.

Test Plan:
- Basic: A=5, B=3, Bin=0 accepted at edge k → out_valid=1 after edge k+4; Diff=2, Bout=0.
- Underflow wrap: A=0, B=1, Bin=0 → Diff=2^100-1 (all ones), Bout=1. A=0, B=0, Bin=1 → Diff all ones, Bout=1. A=B=2^100-1, Bin=0 → Diff=0, Bout=0.
- Slice-boundary borrow propagation: A=2^75, B=1 → Diff=2^75-1 (bits 74:0 set), Bout=0. Confirms carry crosses 3 slice boundaries.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles after out_valid → out_valid, Diff and Bout stay constant.
  - in_valid=1 with new operands during CALC/DONE is ignored (in_ready=0).
  - out_ready=1 → in_ready=1 on the next cycle; the next operation's result matches its own operands.
- Reset mid-operation: assert reset during the 2nd CALC cycle → out_valid=0, Diff=0, Bout=0, in_ready=1 immediately. A fresh A=10, B=4, Bin=1 then yields Diff=5, Bout=0.
- Random regression: 30+ transactions with random 100-bit A/B, random Bin and random out_ready stalls. Compare {Bout, Diff} against the 101-bit reference model (A - B - Bin) mod 2^101; zero mismatches.

Source files
------------

// File: rtl/seq_100bit_subtractor_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// The design side uses the slave modport; a source/sink uses master.
interface seq_100bit_subtractor_if #(
  parameter int WIDTH = 100
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Diff;
  logic             Bout;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout
  );
endinterface

// File: rtl/seq_100bit_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - Bin, one CHUNK slice per clock,
// computed as A + ~B + ~Bin with the carry rippled between slices.
module seq_100bit_subtractor #(
  parameter int WIDTH = 100,
  parameter int CHUNK = 25
) (
  input logic                clk,
  input logic                reset,
  seq_100bit_subtractor_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("WIDTH must be an exact multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_nb;
  logic [WIDTH-1:0] r_diff;
  logic             r_carry;
  logic             r_bout;
  logic             r_out_valid;
  logic [IW-1:0]    r_idx;

  logic [BW-1:0]    w_base;
  logic [CHUNK:0]   w_sum;
  logic             w_last;

  assign w_base = BW'(int'(r_idx) * CHUNK);
  assign w_sum  = {1'b0, r_a[w_base +: CHUNK]}
                + {1'b0, r_nb[w_base +: CHUNK]}
                + {{CHUNK{1'b0}}, r_carry};
  assign w_last = (r_idx == IW'(NCHUNK - 1));

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.Diff      = r_diff;
  assign bus.Bout      = r_bout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_nb        <= '0;
      r_diff      <= '0;
      r_carry     <= 1'b0;
      r_bout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.A;
            r_nb    <= ~bus.B;
            r_carry <= ~bus.Bin;
            r_idx   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_diff[w_base +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry <= w_sum[CHUNK];
          r_idx   <= r_idx + 1'b1;
          // No carry out of the top slice means a borrow was taken.
          if (w_last) begin
            r_bout      <= ~w_sum[CHUNK];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_100bit_subtractor.sv
// Directed and random checks for seq_100bit_subtractor.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_seq_100bit_subtractor;
  localparam int W  = 100;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_100bit_subtractor_if #(.WIDTH(W)) bus ();

  seq_100bit_subtractor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic bin);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.Bin = bin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Bin = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Diff !== '0 || bus.Bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h b=%b exp 0/0/0",
               bus.out_valid, bus.Diff, bus.Bout);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    issue(100'd5, 100'd3, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== NC) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, NC);
    end
    checks++;
    if (bus.Diff !== 100'd2 || bus.Bout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got=%h/%b exp=2/0", bus.Diff, bus.Bout);
    end
    handoff();
  endtask

  task automatic test_wrap();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tbin [3];
    logic [W-1:0] ed [3];
    logic         eb [3];
    int lat;
    ta[0] = '0;         tb[0] = 100'd1;     tbin[0] = 1'b0;
    ed[0] = '1;         eb[0] = 1'b1;
    ta[1] = '0;         tb[1] = '0;         tbin[1] = 1'b1;
    ed[1] = '1;         eb[1] = 1'b1;
    ta[2] = '1;         tb[2] = '1;         tbin[2] = 1'b0;
    ed[2] = '0;         eb[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(ta[i], tb[i], tbin[i]);
      wait_valid(lat);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.Diff !== ed[i] || bus.Bout !== eb[i]) begin
        errors++;
        $display("FAIL wrap%0d got=%h/%b exp=%h/%b",
                 i, bus.Diff, bus.Bout, ed[i], eb[i]);
      end
      handoff();
    end
  endtask

  task automatic test_slice_borrow();
    logic [W-1:0] a;
    logic [W-1:0] exp_d;
    int lat;
    a = '0;
    a[75] = 1'b1;
    exp_d = {25'd0, {75{1'b1}}};
    issue(a, 100'd1, 1'b0);
    wait_valid(lat);
    checks++;
    if (bus.Diff !== exp_d || bus.Bout !== 1'b0) begin
      errors++;
      $display("FAIL slice_borrow got=%h/%b exp=%h/0", bus.Diff, bus.Bout, exp_d);
    end
    handoff();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(100'd100, 100'd30, 1'b1);
    bus.A = 100'd7;
    bus.B = 100'd9;
    bus.Bin = 1'b0;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_calc got=%b exp=0", bus.in_ready);
    end
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.Diff !== 100'd69 ||
          bus.Bout !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b d=%h b=%b r=%b exp 1/45/0/0",
                 c, bus.out_valid, bus.Diff, bus.Bout, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready_handoff got=%b exp=0", bus.in_ready);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_after got r=%b v=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(100'd7, 100'd9, 1'b0);
    wait_valid(lat);
    checks++;
    if (bus.Diff !== {{99{1'b1}}, 1'b0} || bus.Bout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first got=%h/%b exp=ff..fe/1", bus.Diff, bus.Bout);
    end
    handoff();
    issue(100'd50, 100'd8, 1'b1);
    wait_valid(lat);
    checks++;
    if (lat !== NC || bus.Diff !== 100'd41 || bus.Bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second got=%h/%b lat=%0d exp=29/0 lat=%0d",
               bus.Diff, bus.Bout, lat, NC);
    end
    handoff();
  endtask

  task automatic test_reset_mid();
    int lat;
    issue(100'd123, 100'd45, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Diff !== '0 ||
        bus.Bout !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got v=%b d=%h b=%b r=%b exp 0/0/0/1",
               bus.out_valid, bus.Diff, bus.Bout, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(100'd10, 100'd4, 1'b1);
    wait_valid(lat);
    checks++;
    if (bus.Diff !== 100'd5 || bus.Bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh got=%h/%b exp=5/0", bus.Diff, bus.Bout);
    end
    handoff();
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W:0]   e;
    int lat;
    int stall;
    for (int n = 0; n < 32; n++) begin
      a = W'({$urandom, $urandom, $urandom, $urandom});
      b = W'({$urandom, $urandom, $urandom, $urandom});
      if (n % 8 == 3) b = a;
      bin = 1'($urandom_range(0, 1));
      e = {1'b0, a} - {1'b0, b} - (W + 1)'(bin);
      issue(a, b, bin);
      wait_valid(lat);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.Bout, bus.Diff} !== e) begin
        errors++;
        $display("FAIL rand%0d got=%b/%h exp=%b/%h",
                 n, bus.Bout, bus.Diff, e[W], e[W-1:0]);
      end
      handoff();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_slice_borrow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
